// File: rtl/chess_countdown_if.sv
// Game-control inputs and clock-display outputs of the chess countdown timer.
interface chess_countdown_if;
  logic       p1;
  logic       p2;
  logic       Load;
  logic       ff;
  logic [1:0] time_sel;
  logic       inc_en;
  logic [6:0] p1_min;
  logic [6:0] p2_min;
  logic [5:0] p1_sec;
  logic [5:0] p2_sec;
  logic       p1_flag;
  logic       p2_flag;
  logic       tick;

  // Game-state controller side
  modport master (
    output p1, p2, Load, ff, time_sel, inc_en,
    input  p1_min, p2_min, p1_sec, p2_sec, p1_flag, p2_flag, tick
  );

  // Countdown timer side
  modport slave (
    input  p1, p2, Load, ff, time_sel, inc_en,
    output p1_min, p2_min, p1_sec, p2_sec, p1_flag, p2_flag, tick
  );
endinterface

// File: rtl/chess_countdown.sv
// Two-player chess clock: per-player mm:ss countdown with a one-second prescaler,
// per-move increment bonus and sticky time-expired flags.
module chess_countdown #(
  parameter int unsigned TICK_DIV = 50_000_000,
  parameter int unsigned INC_SEC  = 2
) (
  input logic               Clock,
  input logic               Reset,
  chess_countdown_if.slave  bus
);

  typedef enum logic [2:0] {
    StIdle, StLoaded, StRunP1, StRunP2, StHalt, StExpired
  } state_e;

  typedef enum logic [1:0] {LastNone, LastP1, LastP2} last_e;

  localparam logic [25:0] PresMax = 26'(TICK_DIV - 1);

  state_e      state_q, state_d;
  last_e       last_q, last_d;
  logic [25:0] presc_q, presc_d;
  logic [6:0]  p1_min_q, p1_min_d, p2_min_q, p2_min_d;
  logic [5:0]  p1_sec_q, p1_sec_d, p2_sec_q, p2_sec_d;
  logic        p1_flag_q, p1_flag_d, p2_flag_q, p2_flag_d;
  logic        tick_q, tick_d;

  function automatic logic [6:0] preset_min(input logic [1:0] sel);
    logic [6:0] m;
    unique case (sel)
      2'b00:   m = 7'd1;
      2'b01:   m = 7'd3;
      2'b10:   m = 7'd5;
      default: m = 7'd10;
    endcase
    return m;
  endfunction

  // mm:ss minus one second, borrowing from minutes; 00:00 stays put.
  function automatic logic [12:0] dec_time(input logic [6:0] m, input logic [5:0] s);
    logic [12:0] r;
    if (s != 6'd0)      r = {m, s - 6'd1};
    else if (m != 7'd0) r = {m - 7'd1, 6'd59};
    else                r = 13'd0;
    return r;
  endfunction

  // mm:ss plus the bonus, carrying into minutes and clamping at 99:59.
  function automatic logic [12:0] add_bonus(input logic [6:0] m, input logic [5:0] s);
    logic [6:0]  s_sum;
    logic [6:0]  m_sum;
    logic [12:0] r;
    s_sum = {1'b0, s} + 7'(INC_SEC);
    m_sum = m;
    if (s_sum >= 7'd60) begin
      s_sum = s_sum - 7'd60;
      m_sum = m_sum + 7'd1;
    end
    if (m_sum > 7'd99) r = {7'd99, 6'd59};
    else               r = {m_sum, s_sum[5:0]};
    return r;
  endfunction

  // Next-state: ff > Load > single running player > hold.
  always_comb begin
    state_d   = state_q;
    last_d    = last_q;
    presc_d   = presc_q;
    p1_min_d  = p1_min_q;
    p1_sec_d  = p1_sec_q;
    p2_min_d  = p2_min_q;
    p2_sec_d  = p2_sec_q;
    p1_flag_d = p1_flag_q;
    p2_flag_d = p2_flag_q;
    tick_d    = 1'b0;

    if (bus.ff) begin
      state_d   = StIdle;
      last_d    = LastNone;
      presc_d   = '0;
      p1_min_d  = '0;
      p1_sec_d  = '0;
      p2_min_d  = '0;
      p2_sec_d  = '0;
      p1_flag_d = 1'b0;
      p2_flag_d = 1'b0;
    end else if (bus.Load) begin
      state_d   = StLoaded;
      last_d    = LastNone;
      presc_d   = '0;
      p1_min_d  = preset_min(bus.time_sel);
      p1_sec_d  = '0;
      p2_min_d  = preset_min(bus.time_sel);
      p2_sec_d  = '0;
      p1_flag_d = 1'b0;
      p2_flag_d = 1'b0;
    end else begin
      unique case (state_q)
        StLoaded, StHalt, StRunP1, StRunP2: begin
          if (bus.p1 && !bus.p2) begin
            last_d = LastP1;
            if (state_q != StRunP1) begin
              state_d = StRunP1;
              presc_d = '0;
              // P2 just handed the move over: credit P2's bonus.
              if (last_q == LastP2 && bus.inc_en && !p2_flag_q)
                {p2_min_d, p2_sec_d} = add_bonus(p2_min_q, p2_sec_q);
            end else if (presc_q == PresMax) begin
              presc_d = '0;
              tick_d  = 1'b1;
              {p1_min_d, p1_sec_d} = dec_time(p1_min_q, p1_sec_q);
              if (p1_min_d == 7'd0 && p1_sec_d == 6'd0) begin
                p1_flag_d = 1'b1;
                state_d   = StExpired;
              end
            end else begin
              presc_d = presc_q + 26'd1;
            end
          end else if (bus.p2 && !bus.p1) begin
            last_d = LastP2;
            if (state_q != StRunP2) begin
              state_d = StRunP2;
              presc_d = '0;
              if (last_q == LastP1 && bus.inc_en && !p1_flag_q)
                {p1_min_d, p1_sec_d} = add_bonus(p1_min_q, p1_sec_q);
            end else if (presc_q == PresMax) begin
              presc_d = '0;
              tick_d  = 1'b1;
              {p2_min_d, p2_sec_d} = dec_time(p2_min_q, p2_sec_q);
              if (p2_min_d == 7'd0 && p2_sec_d == 6'd0) begin
                p2_flag_d = 1'b1;
                state_d   = StExpired;
              end
            end else begin
              presc_d = presc_q + 26'd1;
            end
          end else if (!bus.p1 && !bus.p2) begin
            // Nobody running: pause after a run, otherwise stay loaded.
            if (state_q == StRunP1 || state_q == StRunP2) begin
              state_d = StHalt;
              presc_d = '0;
            end
          end
          // p1 && p2 is illegal: everything holds.
        end
        default: ;  // StIdle and StExpired wait for Load or ff
      endcase
    end
  end

  // State and registered outputs; Reset clears asynchronously.
  always_ff @(posedge Clock or negedge Reset) begin
    if (!Reset) begin
      state_q   <= StIdle;
      last_q    <= LastNone;
      presc_q   <= '0;
      p1_min_q  <= '0;
      p1_sec_q  <= '0;
      p2_min_q  <= '0;
      p2_sec_q  <= '0;
      p1_flag_q <= 1'b0;
      p2_flag_q <= 1'b0;
      tick_q    <= 1'b0;
    end else begin
      state_q   <= state_d;
      last_q    <= last_d;
      presc_q   <= presc_d;
      p1_min_q  <= p1_min_d;
      p1_sec_q  <= p1_sec_d;
      p2_min_q  <= p2_min_d;
      p2_sec_q  <= p2_sec_d;
      p1_flag_q <= p1_flag_d;
      p2_flag_q <= p2_flag_d;
      tick_q    <= tick_d;
    end
  end

  assign bus.p1_min  = p1_min_q;
  assign bus.p1_sec  = p1_sec_q;
  assign bus.p2_min  = p2_min_q;
  assign bus.p2_sec  = p2_sec_q;
  assign bus.p1_flag = p1_flag_q;
  assign bus.p2_flag = p2_flag_q;
  assign bus.tick    = tick_q;

endmodule

// File: doc/chess_countdown.md
CHESS_COUNTDOWN -- requirements
Module: chess_countdown

Interface
REQ-001 SHALL have parameter TICK_DIV, default 50_000_000, clock cycles per one-second tick (range 2..2^26).
REQ-002 SHALL have parameter INC_SEC, default 2, per-move bonus seconds (range 0..59).
REQ-003 SHALL have port Clock  input  1  system clock; all state updates on its rising edge.
REQ-004 SHALL have port Reset  input  1  asynchronous, active-low reset.
REQ-005 SHALL have port p1  input  1  player 1 running, from the game-state FSM.
REQ-006 SHALL have port p2  input  1  player 2 running, from the game-state FSM.
REQ-007 SHALL have port Load  input  1  load preset time, from the game-state FSM.
REQ-008 SHALL have port ff  input  1  synchronous clear, from the game-state FSM.
REQ-009 SHALL have port time_sel  input  2  preset: 00=01:00, 01=03:00, 10=05:00, 11=10:00.
REQ-010 SHALL have port inc_en  input  1  enables the INC_SEC bonus.
REQ-011 SHALL have ports p1_min, p2_min  output  7 each  minutes 0..99.
REQ-012 SHALL have ports p1_sec, p2_sec  output  6 each  seconds 0..59.
REQ-013 SHALL have ports p1_flag, p2_flag  output  1 each  sticky time-expired flags.
REQ-014 SHALL have port tick  output  1  one-cycle pulse coincident with each decrement edge.

Function
REQ-015 SHALL implement FSM states IDLE, LOADED, RUN_P1, RUN_P2, HALT, EXPIRED.
REQ-016 Input priority each cycle SHALL be ff > Load > (p1 XOR p2) > hold.
REQ-017 ff=1 SHALL go to IDLE: times 00:00, flags 0, prescaler 0, last_player none.
REQ-018 Load=1 (ff=0) SHALL go to LOADED and, every cycle Load is high, set both times to preset(time_sel), clear flags, prescaler 0, last_player none.
REQ-019 From LOADED/HALT/RUN_Px: p1=1,p2=0 SHALL go to RUN_P1; p2=1,p1=0 SHALL go to RUN_P2; p1=p2=0 SHALL go to HALT (after a run) or stay LOADED.
REQ-020 p1=p2=1 SHALL be treated as illegal: hold state, no decrement, prescaler frozen.
REQ-021 IDLE SHALL ignore p1/p2 and leave only on Load.
REQ-022 In RUN_Px the prescaler SHALL count 0..TICK_DIV-1; on the edge where it equals TICK_DIV-1 it SHALL wrap to 0, tick SHALL pulse, and the active player's time SHALL decrement.
REQ-023 The first decrement SHALL occur exactly TICK_DIV cycles after entering RUN_Px.
REQ-024 The prescaler SHALL reset to 0 on any entry to RUN_Px or HALT; it SHALL hold in HALT.
REQ-025 Decrement SHALL be mm:ss-1; ss=00 SHALL borrow to (mm-1):59; 00:00 SHALL never wrap.
REQ-026 A decrement reaching 00:00 SHALL set that player's flag on the same edge and enter EXPIRED.
REQ-027 EXPIRED SHALL freeze both times and tick=0 until Load, ff or Reset.
REQ-028 On entry to RUN_P2 with last_player=P1 and inc_en=1, p1 time SHALL gain INC_SEC seconds on the same edge; symmetric for entry to RUN_P1 with last_player=P2. A pass through HALT SHALL still count as a switch.
REQ-029 Bonus SHALL carry ss>=60 into minutes and saturate at 99:59.
REQ-030 last_player SHALL update to the running player on every RUN_Px cycle.
REQ-031 A bonus SHALL NOT apply in EXPIRED or to a flagged player.
REQ-032 Outputs SHALL be registered; tick SHALL be 0 outside RUN_Px.

Reset
REQ-033 Reset=0 SHALL immediately and asynchronously force IDLE, all times 00:00, flags 0, tick 0, prescaler 0, last_player none.
REQ-034 Release of Reset SHALL take effect at the next Clock edge and SHALL produce no tick that cycle.

Verification (TICK_DIV=4, INC_SEC=2)
REQ-035 Reset, then Load=1 with time_sel=01 for 1 cycle -> both players 03:00, flags 0.
REQ-036 From 01:00, p1=1 for 4 cycles -> one tick, p1 = 00:59, p2 = 01:00.
REQ-037 Preset p1=00:01 in RUN_P1 -> after 4 cycles p1 = 00:00, p1_flag=1, EXPIRED; further p1/p2 activity leaves times unchanged.
REQ-038 With inc_en=1: run P1, then HALT, then p2=1 -> on the p2 entry edge p1 gains 2 s (00:58 -> 01:00); at 99:59 p1 remains 99:59.
REQ-039 p1=p2=1 for 10 cycles -> no change to times, no tick; Load and ff asserted together -> IDLE, 00:00.
REQ-040 Reset asserted mid-run between clock edges -> outputs clear immediately, without waiting for a Clock edge.
